// File: rtl/lsu_stage_if.sv
// Bus bundle around lsu_stage: execute-side request, cache response, write-back and forwarding.
// The slave modport is the LSU view; the master modport is the surrounding pipeline's view.
interface lsu_stage_if #(
    parameter int unsigned RegWidth = 64,
    parameter int unsigned INSTWide = 32
);
    logic                exu_to_lsu_valid;
    logic                lsu_allow_in;
    logic [2:0]          exu_MemOP;
    logic                exu_MemWr;
    logic [RegWidth-1:0] exu_ALUres;
    logic [RegWidth-1:0] exu_R_rs1;
    logic                exu_Regwr;
    logic [1:0]          exu_RegSrc;
    logic [INSTWide-1:0] exu_inst;
    logic [RegWidth-1:0] exu_pc;

    logic                cache_resp_valid;
    logic [RegWidth-1:0] cache_rdata;

    logic                lsu_to_wbu_valid;
    logic                wbu_allow_in;
    logic [RegWidth-1:0] wb_data;
    logic                wb_Regwr;
    logic [4:0]          wb_rd;
    logic [INSTWide-1:0] wb_inst;
    logic [RegWidth-1:0] wb_pc;
    logic [RegWidth-1:0] wb_R_rs1;

    logic                lsu_fwd_valid;
    logic [4:0]          lsu_fwd_rd;
    logic [RegWidth-1:0] lsu_fwd_data;

    modport master (
        output exu_to_lsu_valid, exu_MemOP, exu_MemWr, exu_ALUres, exu_R_rs1, exu_Regwr,
               exu_RegSrc, exu_inst, exu_pc, cache_resp_valid, cache_rdata, wbu_allow_in,
        input  lsu_allow_in, lsu_to_wbu_valid, wb_data, wb_Regwr, wb_rd, wb_inst, wb_pc,
               wb_R_rs1, lsu_fwd_valid, lsu_fwd_rd, lsu_fwd_data
    );

    modport slave (
        input  exu_to_lsu_valid, exu_MemOP, exu_MemWr, exu_ALUres, exu_R_rs1, exu_Regwr,
               exu_RegSrc, exu_inst, exu_pc, cache_resp_valid, cache_rdata, wbu_allow_in,
        output lsu_allow_in, lsu_to_wbu_valid, wb_data, wb_Regwr, wb_rd, wb_inst, wb_pc,
               wb_R_rs1, lsu_fwd_valid, lsu_fwd_rd, lsu_fwd_data
    );
endinterface

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: waits for the data-cache response, aligns/extends load data,
// offers the result to write-back and forwards it to execute.
module lsu_stage #(
    parameter int unsigned RegWidth = 64,
    parameter int unsigned INSTWide = 32
) (
    input  logic        clk,
    input  logic        rst,
    lsu_stage_if.slave  bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
    localparam logic [2:0] NoMem  = 3'b011;

    logic [1:0]          state_q, state_d;
    logic                valid_q, valid_d;
    logic [RegWidth-1:0] load_q, load_d;

    logic [2:0]          memop_q;
    logic                memwr_q;
    logic [RegWidth-1:0] alures_q;
    logic [RegWidth-1:0] rs1_q;
    logic                regwr_q;
    logic [1:0]          regsrc_q;
    logic [INSTWide-1:0] inst_q;
    logic [RegWidth-1:0] pc_q;

    logic                ready_go;
    logic                out_valid;
    logic                allow_in;
    logic                accept;
    logic                retire;
    logic                is_load;
    logic [RegWidth-1:0] load_src;
    logic [RegWidth-1:0] shifted;
    logic [RegWidth-1:0] load_ext;
    logic [RegWidth-1:0] wb_data;
    logic [5:0]          shamt;

    assign ready_go  = (state_q == StDone) | ((state_q == StWait) & bus.cache_resp_valid);
    assign out_valid = valid_q & ready_go;
    assign allow_in  = ~valid_q | (ready_go & bus.wbu_allow_in);
    assign accept    = bus.exu_to_lsu_valid & allow_in;
    assign retire    = out_valid & bus.wbu_allow_in;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        load_d  = load_q;
        if (retire) begin
            valid_d = 1'b0;
            state_d = StIdle;
        end else if ((state_q == StWait) && bus.cache_resp_valid) begin
            // Response arrived under a write-back stall: keep the raw doubleword for DONE.
            state_d = StDone;
            load_d  = bus.cache_rdata;
        end
        if (accept) begin
            valid_d = 1'b1;
            state_d = (bus.exu_MemOP != NoMem) ? StWait : StDone;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            load_q   <= '0;
            memop_q  <= '0;
            memwr_q  <= 1'b0;
            alures_q <= '0;
            rs1_q    <= '0;
            regwr_q  <= 1'b0;
            regsrc_q <= '0;
            inst_q   <= '0;
            pc_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            load_q  <= load_d;
            if (accept) begin
                memop_q  <= bus.exu_MemOP;
                memwr_q  <= bus.exu_MemWr;
                alures_q <= bus.exu_ALUres;
                rs1_q    <= bus.exu_R_rs1;
                regwr_q  <= bus.exu_Regwr;
                regsrc_q <= bus.exu_RegSrc;
                inst_q   <= bus.exu_inst;
                pc_q     <= bus.exu_pc;
            end
        end
    end

    // Misalignment is not checked: the low address bits only select the byte shift.
    assign load_src = (state_q == StDone) ? load_q : bus.cache_rdata;
    assign shamt    = {alures_q[2:0], 3'b000};
    assign shifted  = load_src >> shamt;

    always_comb begin
        load_ext = shifted;
        case (memop_q[1:0])
            2'd0: load_ext = memop_q[2] ? {{(RegWidth-8){1'b0}}, shifted[7:0]}
                                        : {{(RegWidth-8){shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = memop_q[2] ? {{(RegWidth-16){1'b0}}, shifted[15:0]}
                                        : {{(RegWidth-16){shifted[15]}}, shifted[15:0]};
            2'd2: load_ext = memop_q[2] ? {{(RegWidth-32){1'b0}}, shifted[31:0]}
                                        : {{(RegWidth-32){shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    assign is_load = (memop_q != NoMem) & ~memwr_q;
    assign wb_data = ((regsrc_q == 2'd1) && is_load) ? load_ext : alures_q;

    assign bus.lsu_allow_in     = allow_in;
    assign bus.lsu_to_wbu_valid = out_valid;
    assign bus.wb_data          = wb_data;
    assign bus.wb_Regwr         = regwr_q;
    assign bus.wb_rd            = inst_q[11:7];
    assign bus.wb_inst          = inst_q;
    assign bus.wb_pc            = pc_q;
    assign bus.wb_R_rs1         = rs1_q;
    assign bus.lsu_fwd_valid    = out_valid & regwr_q & (inst_q[11:7] != 5'd0);
    assign bus.lsu_fwd_rd       = inst_q[11:7];
    assign bus.lsu_fwd_data     = wb_data;
endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: stimulus pushes expected retirements, a negedge monitor
// pops and compares them whenever write-back accepts a result.
module tb_lsu_stage;
    logic clk;
    logic rst;

    lsu_stage_if #(.RegWidth(64), .INSTWide(32)) bus ();

    lsu_stage #(.RegWidth(64), .INSTWide(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic        regwr;
        logic        fwd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.lsu_to_wbu_valid && bus.wbu_allow_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire got wb_data=%h want no retirement", bus.wb_data);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_data", bus.wb_data, mon_e.data);
                chk("wb_rd", {59'd0, bus.wb_rd}, {59'd0, mon_e.rd});
                chk("wb_pc", bus.wb_pc, mon_e.pc);
                chk("wb_R_rs1", bus.wb_R_rs1, mon_e.rs1);
                chk("wb_Regwr", {63'd0, bus.wb_Regwr}, {63'd0, mon_e.regwr});
                chk("fwd_valid", {63'd0, bus.lsu_fwd_valid}, {63'd0, mon_e.fwd});
                chk("fwd_rd", {59'd0, bus.lsu_fwd_rd}, {59'd0, mon_e.rd});
                chk("fwd_data", bus.lsu_fwd_data, mon_e.data);
            end
        end
    end

    // Offers one instruction; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] memop, input logic memwr, input logic [63:0] alures,
                        input logic regwr, input logic [1:0] regsrc, input logic [4:0] rd,
                        input logic [63:0] pc, input bit push, input logic [63:0] exp_data);
        int   n;
        exp_t e;
        n = 0;
        bus.exu_MemOP        = memop;
        bus.exu_MemWr        = memwr;
        bus.exu_ALUres       = alures;
        bus.exu_R_rs1        = pc ^ 64'h5A5A;
        bus.exu_Regwr        = regwr;
        bus.exu_RegSrc       = regsrc;
        bus.exu_inst         = {20'h00000, rd, 7'b0000011};
        bus.exu_pc           = pc;
        bus.exu_to_lsu_valid = 1'b1;
        while (!bus.lsu_allow_in && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got allow_in=0 want 1 within 50 cycles");
        end
        if (push) begin
            e.data  = exp_data;
            e.rd    = rd;
            e.pc    = pc;
            e.rs1   = pc ^ 64'h5A5A;
            e.regwr = regwr;
            e.fwd   = regwr && (rd != 5'd0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.exu_to_lsu_valid = 1'b0;
    endtask

    task automatic resp_pulse(input logic [63:0] rdata);
        bus.cache_resp_valid = 1'b1;
        bus.cache_rdata      = rdata;
        @(negedge clk);
        chk("resp_cycle_valid", {63'd0, bus.lsu_to_wbu_valid}, 64'd1);
        @(posedge clk);
        #1;
        bus.cache_resp_valid = 1'b0;
        bus.cache_rdata      = 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    initial begin
        int n;
        rst                  = 1'b0;
        bus.exu_to_lsu_valid = 1'b0;
        bus.exu_MemOP        = 3'b011;
        bus.exu_MemWr        = 1'b0;
        bus.exu_ALUres       = '0;
        bus.exu_R_rs1        = '0;
        bus.exu_Regwr        = 1'b0;
        bus.exu_RegSrc       = 2'd0;
        bus.exu_inst         = '0;
        bus.exu_pc           = '0;
        bus.cache_resp_valid = 1'b0;
        bus.cache_rdata      = '0;
        bus.wbu_allow_in     = 1'b1;

        #1;
        chk("rst_allow_in", {63'd0, bus.lsu_allow_in}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        chk("rst_wb_data", bus.wb_data, 64'd0);
        chk("rst_fwd_valid", {63'd0, bus.lsu_fwd_valid}, 64'd0);
        chk("rst_wb_pc", bus.wb_pc, 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op with latency 1, then four back-to-back ALU ops.
        send(3'b011, 1'b0, 64'h1234, 1'b1, 2'd0, 5'd5, 64'h100, 1'b1, 64'h1234);
        chk("alu_latency1", {63'd0, bus.lsu_to_wbu_valid}, 64'd1);
        for (int i = 0; i < 4; i++)
            send(3'b011, 1'b0, 64'hA000 + 64'(i), 1'b1, 2'd0, 5'(8 + i), 64'h200 + 64'(4 * i),
                 1'b1, 64'hA000 + 64'(i));
        @(negedge clk);
        chk("b2b_allow_in", {63'd0, bus.lsu_allow_in}, 64'd1);
        @(posedge clk);
        #1;

        // lb at offset 3, response two cycles after accept.
        send(3'b000, 1'b0, 64'h8000_0003, 1'b1, 2'd1, 5'd6, 64'h300, 1'b1,
             64'hFFFF_FFFF_FFFF_FF80);
        @(negedge clk);
        chk("lb_wait_no_offer", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        @(posedge clk);
        #1;
        resp_pulse(64'h0000_0000_8000_0000);

        // lhu at offset 2, lw sign-extended at offset 4, ld full doubleword.
        send(3'b101, 1'b0, 64'h1002, 1'b1, 2'd1, 5'd7, 64'h304, 1'b1, 64'h0000_0000_0000_F00D);
        resp_pulse(64'h0000_0000_F00D_0000);
        send(3'b010, 1'b0, 64'h1004, 1'b1, 2'd1, 5'd9, 64'h308, 1'b1, 64'hFFFF_FFFF_8765_4321);
        resp_pulse(64'h8765_4321_0000_0000);
        send(3'b111, 1'b0, 64'h1010, 1'b1, 2'd1, 5'd10, 64'h30C, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        resp_pulse(64'hDEAD_BEEF_CAFE_F00D);

        // lh whose response lands during a write-back stall.
        bus.wbu_allow_in = 1'b0;
        send(3'b001, 1'b0, 64'h2006, 1'b1, 2'd1, 5'd11, 64'h400, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF);
        bus.cache_resp_valid = 1'b1;
        bus.cache_rdata      = 64'hBEEF_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, bus.lsu_to_wbu_valid}, 64'd1);
            chk("stall_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_BEEF);
            chk("stall_allow_in", {63'd0, bus.lsu_allow_in}, 64'd0);
            @(posedge clk);
            #1;
            bus.cache_resp_valid = 1'b0;
            bus.cache_rdata      = 64'h1111_2222_3333_4444;
        end
        bus.wbu_allow_in = 1'b1;
        @(negedge clk);
        chk("stall_release_allow_in", {63'd0, bus.lsu_allow_in}, 64'd1);
        @(posedge clk);
        #1;

        // Spurious response while idle, then sd that waits for its completion.
        bus.cache_resp_valid = 1'b1;
        @(negedge clk);
        chk("spurious_no_offer", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        chk("spurious_allow_in", {63'd0, bus.lsu_allow_in}, 64'd1);
        @(posedge clk);
        #1;
        bus.cache_resp_valid = 1'b0;
        @(negedge clk);
        chk("spurious_after", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        @(posedge clk);
        #1;
        send(3'b111, 1'b1, 64'h2000, 1'b0, 2'd0, 5'd0, 64'h500, 1'b1, 64'h2000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("sd_no_offer", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        resp_pulse(64'h0123_4567_89AB_CDEF);

        // Reset while waiting on a load; the late response must be ignored.
        send(3'b010, 1'b0, 64'h3008, 1'b1, 2'd1, 5'd12, 64'h600, 1'b0, 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_wait_valid", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        chk("rst_wait_allow_in", {63'd0, bus.lsu_allow_in}, 64'd1);
        chk("rst_wait_wb_data", bus.wb_data, 64'd0);
        chk("rst_wait_wb_pc", bus.wb_pc, 64'd0);
        chk("rst_wait_fwd", {63'd0, bus.lsu_fwd_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cache_resp_valid = 1'b1;
        bus.cache_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("late_resp_ignored", {63'd0, bus.lsu_to_wbu_valid}, 64'd0);
        @(posedge clk);
        #1;
        bus.cache_resp_valid = 1'b0;

        // ALU op to x0 after reset: retires but never forwards.
        send(3'b011, 1'b0, 64'h77, 1'b1, 2'd0, 5'd0, 64'h700, 1'b1, 64'h77);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
